// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host types, 50 MHz timing defaults and command bytes.
package ps2_pkg;
   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, PAR, STOP, ACK, WAITIDLE} ps2_tx_state_t;
   localparam int DEF_INHIBIT_CYCLES = 5000;
   localparam int DEF_TIMEOUT_CYCLES = 750000;
   localparam logic [7:0] CMD_RESET = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] CMD_ACK = 8'hFA;
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte handshake and status between a requester and the PS/2 transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   logic busy;
   logic done;
   logic error;
   modport master (output tx_data, tx_valid, input tx_ready, busy, done, error);
   modport slave (input tx_data, tx_valid, output tx_ready, busy, done, error);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizers for the PS/2 pads plus clock falling-edge detect.
module ps2_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_s,
   output logic data_s,
   output logic fall
);
   logic [1:0] cm, dm;
   logic clk_q;
   // Idle PS/2 lines are high, so the chain resets to 1 to avoid a false edge.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cm <= 2'b11;
         dm <= 2'b11;
         clk_q <= 1'b1;
      end else begin
         cm <= {cm[0], ps2_clk_in};
         dm <= {dm[0], ps2_data_in};
         clk_q <= cm[1];
      end
   assign clk_s = cm[1];
   assign data_s = dm[1];
   assign fall = clk_q & ~cm[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (request-to-send, odd parity, ack check, timeout).
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   ps2_host_tx_if.slave bus,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic ps2_clk_oe,
   output logic ps2_data_oe
);
   localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
   ps2_tx_state_t state;
   logic [CW-1:0] cnt;
   logic [7:0] shreg;
   logic par;
   logic [3:0] bitcnt;
   logic clk_s, data_s, fall, timeout;
   ps2_line_sync u_sync (
      .clk(clk),
      .reset(reset),
      .ps2_clk_in(ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .clk_s(clk_s),
      .data_s(data_s),
      .fall(fall)
   );
   assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign bus.tx_ready = (state == IDLE);
   assign bus.busy = (state != IDLE);
   // done/error pulse while the FSM still reads busy; it drops to IDLE the following cycle.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         shreg <= '0;
         par <= 1'b0;
         bitcnt <= '0;
         ps2_clk_oe <= 1'b0;
         ps2_data_oe <= 1'b0;
         bus.done <= 1'b0;
         bus.error <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         bus.error <= 1'b0;
         if (bus.done || bus.error) state <= IDLE;
         else case (state)
            IDLE: if (bus.tx_valid) begin
               shreg <= bus.tx_data;
               par <= ~^bus.tx_data;
               bitcnt <= '0;
               cnt <= '0;
               ps2_clk_oe <= 1'b1;
               state <= INHIBIT;
            end
            INHIBIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(INHIBIT_CYCLES - 2)) ps2_data_oe <= 1'b1;
               if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                  ps2_clk_oe <= 1'b0;
                  cnt <= '0;
                  state <= REQ;
               end
            end
            default: if (timeout) begin
               ps2_clk_oe <= 1'b0;
               ps2_data_oe <= 1'b0;
               bus.error <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
               case (state)
                  REQ: if (fall) begin
                     ps2_data_oe <= ~shreg[0];
                     bitcnt <= 4'd1;
                     state <= DATA;
                  end
                  DATA: if (fall) begin
                     if (bitcnt == 4'd8) begin
                        ps2_data_oe <= ~par;
                        state <= PAR;
                     end else begin
                        ps2_data_oe <= ~shreg[bitcnt[2:0]];
                        bitcnt <= bitcnt + 1'b1;
                     end
                  end
                  PAR: if (fall) begin
                     ps2_data_oe <= 1'b0;
                     state <= STOP;
                  end
                  STOP: if (fall) state <= ACK;
                  ACK: if (data_s) bus.error <= 1'b1;
                     else state <= WAITIDLE;
                  WAITIDLE: if (clk_s && data_s) bus.done <= 1'b1;
                  default: ;
               endcase
            end
         endcase
      end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a 40-cycle-period PS/2 device model on wired-AND pads.
module tb_ps2_host_tx;
   import ps2_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   int n_chk = 0, n_fail = 0;
   int cyc = 0, n_done = 0, n_err = 0, n_both = 0, n_acc = 0, done_cyc = -1, acc_cyc = -1;
   int k, nd0, ne0, na0;
   logic [7:0] acc_data = '0;
   logic [9:0] s;
   ps2_host_tx_if bus();
   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;
   always #5 clk = ~clk;
   ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(4000)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .ps2_clk_in(ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );
   always @(posedge clk) begin
      if (bus.done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (bus.error) n_err++;
      if (bus.done && bus.error) n_both++;
      if (bus.tx_valid && bus.tx_ready) begin
         n_acc++;
         acc_cyc = cyc;
         acc_data = bus.tx_data;
      end
      cyc++;
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Called at a negedge with the DUT idle; returns at the first REQ cycle.
   task automatic send(input logic [7:0] b, input bit hold, input logic [7:0] nxt, input string tag);
      int n = 0, d = 0;
      bus.tx_data = b;
      bus.tx_valid = 1'b1;
      tick(1);
      if (hold) bus.tx_data = nxt;
      else bus.tx_valid = 1'b0;
      chk({tag, "_clk_oe_on"}, ps2_clk_oe, 1);
      chk({tag, "_busy"}, bus.busy, 1);
      while (ps2_clk_oe && n < 100) begin
         n++;
         if (ps2_data_oe) d++;
         tick(1);
      end
      chk({tag, "_inhibit_len"}, n, 20);
      chk({tag, "_start_len"}, d, 1);
      chk({tag, "_req_data_low"}, ps2_data_oe, 1);
   endtask
   task automatic dev_run(input bit ack, output logic [9:0] smp);
      smp = '0;
      tick(5);
      for (int i = 0; i < 11; i++) begin
         dev_clk = 1'b0;
         tick(20);
         dev_clk = 1'b1;
         if (i < 10) smp[i] = ps2_data_in;
         if (i == 9 && ack) dev_data = 1'b0;
         if (i == 10) dev_data = 1'b1;
         tick(20);
      end
   endtask
   initial begin
      bus.tx_valid = 1'b0;
      bus.tx_data = '0;
      tick(3);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_ready", bus.tx_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      reset = 1'b0;
      tick(2);
      send(CMD_ENABLE, 1'b0, 8'h00, "f4");
      dev_run(1'b1, s);
      chk("f4_bits", s[7:0], 8'hF4);
      chk("f4_par", s[8], 0);
      chk("f4_stop", s[9], 1);
      chk("f4_done", n_done, 1);
      chk("f4_err", n_err, 0);
      chk("f4_ready", bus.tx_ready, 1);
      chk("f4_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      send(CMD_RESET, 1'b0, 8'h00, "ff");
      dev_run(1'b1, s);
      chk("ff_bits", s[7:0], 8'hFF);
      chk("ff_par", s[8], 1);
      chk("ff_stop", s[9], 1);
      chk("ff_done", n_done, 2);
      chk("ff_err", n_err, 0);
      send(8'hA5, 1'b0, 8'h00, "noack");
      dev_run(1'b0, s);
      chk("noack_bits", s[7:0], 8'hA5);
      chk("noack_par", s[8], 1);
      chk("noack_err", n_err, 1);
      chk("noack_done", n_done, 2);
      chk("noack_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("noack_ready", bus.tx_ready, 1);
      send(8'h12, 1'b0, 8'h00, "to");
      k = 0;
      while (!bus.error && k < 5000) begin
         tick(1);
         k++;
      end
      chk("to_cycles", k, 4000);
      chk("to_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("to_ready_pulse", bus.tx_ready, 0);
      tick(1);
      chk("to_ready_after", bus.tx_ready, 1);
      chk("to_err", n_err, 2);
      chk("to_done", n_done, 2);
      nd0 = n_done;
      ne0 = n_err;
      send(8'hE3, 1'b0, 8'h00, "rst");
      tick(5);
      for (int i = 0; i < 4; i++) begin
         dev_clk = 1'b0;
         tick(20);
         dev_clk = 1'b1;
         tick(20);
      end
      dev_clk = 1'b0;
      tick(5);
      chk("rst_d4_driven", ps2_data_oe, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("rst_async_busy", bus.busy, 0);
      dev_clk = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      chk("rst_idle_ready", bus.tx_ready, 1);
      chk("rst_no_done", n_done, nd0);
      chk("rst_no_err", n_err, ne0);
      nd0 = n_done;
      na0 = n_acc;
      send(CMD_ENABLE, 1'b1, 8'hF3, "b2b");
      dev_run(1'b1, s);
      chk("b2b_first_bits", s[7:0], 8'hF4);
      chk("b2b_accept_cycle", acc_cyc, done_cyc + 1);
      chk("b2b_accept_data", acc_data, 8'hF3);
      bus.tx_valid = 1'b0;
      k = 0;
      while (ps2_clk_oe && k < 100) begin
         tick(1);
         k++;
      end
      chk("b2b_req", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      dev_run(1'b1, s);
      chk("b2b_second_bits", s[7:0], 8'hF3);
      chk("b2b_second_par", s[8], 1);
      chk("b2b_done", n_done, nd0 + 2);
      chk("b2b_acc", n_acc, na0 + 2);
      chk("b2b_err", n_err, ne0);
      chk("never_both", n_both, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
